// File: rtl/adder_pkg.sv
// Shared constants for the adder result FIFO slice.
// The result word is {cout, sum}, so it is one bit wider than the adder.
package adder_pkg;

  localparam int N_DEF     = 4;
  localparam int LAT_DEF   = 2;
  localparam int DEPTH_DEF = 4;
  localparam int RES_W_DEF = N_DEF + 1;

endpackage

// File: rtl/valid_delay.sv
// LAT-stage valid shift line tracking issues in flight through the adder.
// occ counts the set stages and is used for credit accounting.
module valid_delay
  import adder_pkg::*;
#(
  parameter int LAT = LAT_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       din,
  output logic                       dout,
  output logic [$clog2(LAT+1)-1:0]   occ
);

  localparam int OW = $clog2(LAT + 1);

  logic [LAT-1:0] sr;

  always_ff @(posedge clk) begin
    if (rst) begin
      sr <= '0;
    end else begin
      sr[0] <= din;
      for (int i = 1; i < LAT; i++) begin
        sr[i] <= sr[i-1];
      end
    end
  end

  assign dout = sr[LAT-1];

  always_comb begin
    occ = '0;
    for (int i = 0; i < LAT; i++) begin
      occ = occ + OW'(sr[i]);
    end
  end

endmodule

// File: rtl/adder_result_fifo.sv
// Show-ahead result FIFO behind a fixed-latency adder.
// Issues are credited against free entries so results are never dropped.
module adder_result_fifo
  import adder_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int LAT   = LAT_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N-1:0]             sum_in,
  input  logic                     cout_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [N:0]               out_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     ovf_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int OW = $clog2(LAT + 1);

  logic [N:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [OW-1:0] occ;
  logic          dl_out;
  logic          push;
  logic          issue;
  logic          pop;
  logic          full;
  logic          wr_en;
  logic          drop;

  valid_delay #(.LAT(LAT)) u_dly (
    .clk  (clk),
    .rst  (rst),
    .din  (issue),
    .dout (dl_out),
    .occ  (occ)
  );

  assign push      = dl_out;
  assign in_ready  = (int'(count) + int'(occ)) < DEPTH;
  assign issue     = in_valid && in_ready;
  assign out_valid = count != '0;
  assign out_data  = mem[rd_ptr];
  assign pop       = out_valid && out_ready;
  assign full      = count == CW'(DEPTH);
  // When full, a simultaneous pop frees the slot the push lands in.
  assign wr_en     = push && (!full || pop);
  assign drop      = push && full && !pop;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= {cout_in, sum_in};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ovf_err <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop) begin
        ovf_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_adder_result_fifo.sv
// Directed bench for adder_result_fifo with a behavioural pipelined adder.
// Forced delay-line pushes reach the full-FIFO corner cases.
module tb_adder_result_fifo;

  localparam int N     = 4;
  localparam int LAT   = 2;
  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] sum_in;
  logic         cout_in;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [N:0]   out_data;
  logic [2:0]   count;
  logic         ovf_err;

  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;
  logic         cin = 1'b0;
  logic [N:0]   pipe [LAT];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    pipe[0] <= {1'b0, a} + {1'b0, b} + {4'b0, cin};
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign {cout_in, sum_in} = pipe[LAT-1];

  adder_result_fifo #(.N(N), .LAT(LAT), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sum_in    (sum_in),
    .cout_in   (cout_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count),
    .ovf_err   (ovf_err)
  );

  logic [N-1:0] fa [4] = '{4'h1, 4'h3, 4'hf, 4'h8};
  logic [N-1:0] fb [4] = '{4'h2, 4'h4, 4'hf, 4'h8};
  logic         fc [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
  logic [N:0]   fexp [4] = '{5'h03, 5'h08, 5'h1f, 5'h10};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic fill4();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a = fa[i]; b = fb[i]; cin = fc[i]; in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    for (int i = 0; i < LAT + 1; i++) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid got %b want 0", out_valid);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready got %b want 1", in_ready);
    end
    checks++;
    if (count !== 3'd0) begin
      errors++; $display("FAIL reset_count got %0d want 0", count);
    end
    checks++;
    if (ovf_err !== 1'b0) begin
      errors++; $display("FAIL reset_ovf got %b want 0", ovf_err);
    end
  endtask

  task automatic test_single();
    out_ready = 1'b0;
    a = 4'h7; b = 4'h9; cin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL single_early1 got %b want 0", out_valid);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL single_early2 got %b want 0", out_valid);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 5'h10 || count !== 3'd1) begin
      errors++;
      $display("FAIL single_result got v=%b d=%h c=%0d want v=1 d=10 c=1",
               out_valid, out_data, count);
    end
    tick();
    checks++;
    if (out_data !== 5'h10 || count !== 3'd1) begin
      errors++; $display("FAIL single_hold got d=%h c=%0d want 10 1", out_data, count);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (count !== 3'd0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL single_pop got c=%0d v=%b want 0 0", count, out_valid);
    end
  endtask

  task automatic test_fill();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a = fa[i]; b = fb[i]; cin = fc[i]; in_valid = 1'b1;
      checks++;
      if (in_ready !== 1'b1) begin
        errors++; $display("FAIL fill_ready%0d got %b want 1", i, in_ready);
      end
      tick();
    end
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL fill_ready_drop got %b want 0", in_ready);
    end
    a = 4'h5; b = 4'h5; cin = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    in_valid = 1'b0;
    tick();
    checks++;
    if (count !== 3'd4 || ovf_err !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL fill_full got c=%0d o=%b r=%b want 4 0 0", count, ovf_err, in_ready);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out_data !== fexp[i]) begin
        errors++; $display("FAIL fill_drain%0d got %h want %h", i, out_data, fexp[i]);
      end
      tick();
    end
    out_ready = 1'b0;
    tick(); tick();
    checks++;
    if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL fill_empty got c=%0d v=%b r=%b want 0 0 1", count, out_valid, in_ready);
    end
  endtask

  task automatic test_full_pushpop();
    fill4();
    a = 4'h2; b = 4'h3; cin = 1'b0;
    tick(); tick(); tick();
    force dut.push = 1'b1;
    out_ready = 1'b1;
    tick();
    release dut.push;
    out_ready = 1'b0;
    checks++;
    if (count !== 3'd4 || ovf_err !== 1'b0) begin
      errors++; $display("FAIL pushpop_full got c=%0d o=%b want 4 0", count, ovf_err);
    end
    out_ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      logic [N:0] e;
      e = (i < 4) ? fexp[i] : 5'h05;
      checks++;
      if (out_data !== e) begin
        errors++; $display("FAIL pushpop_order%0d got %h want %h", i, out_data, e);
      end
      tick();
    end
    out_ready = 1'b0;
    checks++;
    if (count !== 3'd0) begin
      errors++; $display("FAIL pushpop_empty got %0d want 0", count);
    end
  endtask

  task automatic test_overflow();
    fill4();
    a = 4'h1; b = 4'h1; cin = 1'b0;
    tick(); tick(); tick();
    force dut.push = 1'b1;
    tick();
    release dut.push;
    checks++;
    if (count !== 3'd4 || ovf_err !== 1'b1) begin
      errors++; $display("FAIL ovf_set got c=%0d o=%b want 4 1", count, ovf_err);
    end
    tick(); tick(); tick();
    checks++;
    if (ovf_err !== 1'b1) begin
      errors++; $display("FAIL ovf_sticky got %b want 1", ovf_err);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out_data !== fexp[i]) begin
        errors++; $display("FAIL ovf_keep%0d got %h want %h", i, out_data, fexp[i]);
      end
      tick();
    end
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || ovf_err !== 1'b1) begin
      errors++; $display("FAIL ovf_after_drain got v=%b o=%b want 0 1", out_valid, ovf_err);
    end
    do_reset();
    checks++;
    if (ovf_err !== 1'b0) begin
      errors++; $display("FAIL ovf_clear got %b want 0", ovf_err);
    end
  endtask

  task automatic test_reset_midflight();
    out_ready = 1'b0;
    a = 4'h6; b = 4'h1; cin = 1'b1; in_valid = 1'b1;
    tick();
    a = 4'h2; b = 4'h2; cin = 1'b0;
    tick();
    in_valid = 1'b0;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL midflight%0d got c=%0d v=%b r=%b want 0 0 1",
                 i, count, out_valid, in_ready);
      end
      tick();
    end
  endtask

  task automatic test_wrap();
    logic [N:0] q [$];
    logic [N:0] e;
    int bad = 0;
    int over = 0;
    for (int i = 0; i < 1000; i++) begin
      a = N'($urandom); b = N'($urandom); cin = 1'($urandom);
      in_valid = 1'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      if (count > 3'd4) over++;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          bad++;
        end else begin
          e = q.pop_front();
          if (out_data !== e) begin
            bad++;
            if (bad < 5) $display("FAIL wrap_data got %h want %h", out_data, e);
          end
        end
      end
      if (in_valid && in_ready) q.push_back({1'b0, a} + {1'b0, b} + {4'b0, cin});
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      #1;
      if (out_valid) begin
        if (q.size() == 0) begin
          bad++;
        end else begin
          e = q.pop_front();
          if (out_data !== e) bad++;
        end
      end
      tick();
    end
    out_ready = 1'b0;
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL wrap_order got %0d bad want 0", bad);
    end
    checks++;
    if (over != 0) begin
      errors++; $display("FAIL wrap_count_bound got %0d over want 0", over);
    end
    checks++;
    if (q.size() != 0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL wrap_leftover got q=%0d v=%b want 0 0", q.size(), out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_full_pushpop();
    test_overflow();
    test_reset_midflight();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
